// File: rtl/dest_reg_pipe.sv
// Destination-register select plus an in-flight pipeline of (dest, valid, load) entries.
// Produces regfile write port, forwarding selects and a load-use stall request.
module dest_reg_pipe #(
  parameter int unsigned BR       = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LINK_REG = 31,
  localparam int unsigned FW      = $clog2(STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BR-1:0]          rd,
  input  logic [BR-1:0]          rt,
  input  logic [BR-1:0]          rs,
  input  logic [1:0]             dst_sel,
  input  logic                   reg_write,
  input  logic                   is_load,
  input  logic                   stall,
  input  logic                   flush,
  output logic [STAGES*BR-1:0]   dest_q,
  output logic [STAGES-1:0]      valid_q,
  output logic [BR-1:0]          wb_dest,
  output logic                   wb_we,
  output logic [FW-1:0]          fwd_rs,
  output logic [FW-1:0]          fwd_rt,
  output logic                   load_use
);

  logic [STAGES*BR-1:0] dest_d;
  logic [STAGES-1:0]    valid_d;
  logic [STAGES-1:0]    load_q;
  logic [STAGES-1:0]    load_d;
  logic [BR-1:0]        sel;
  logic                 entry_valid;
  logic                 bubble;

  // Decode-stage destination select and next-state shift of the entry pipeline
  always_comb begin
    sel         = '0;
    entry_valid = 1'b0;
    bubble      = stall | flush;
    dest_d      = '0;
    valid_d     = '0;
    load_d      = '0;

    case (dst_sel)
      2'b00:   sel = rd;
      2'b01:   sel = rt;
      2'b10:   sel = BR'(LINK_REG);
      default: sel = '0;
    endcase
    entry_valid = reg_write & (dst_sel != 2'b11) & (sel != '0);

    // Older stages advance unconditionally so WB retires even during a stall
    dest_d[STAGES*BR-1:BR] = dest_q[(STAGES-1)*BR-1:0];
    valid_d[STAGES-1:1]    = valid_q[STAGES-2:0];
    load_d[STAGES-1:1]     = load_q[STAGES-2:0];

    if (!bubble) begin
      dest_d[BR-1:0] = sel;
      valid_d[0]     = entry_valid;
      load_d[0]      = is_load & entry_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q  <= '0;
      valid_q <= '0;
      load_q  <= '0;
    end else begin
      dest_q  <= dest_d;
      valid_q <= valid_d;
      load_q  <= load_d;
    end
  end

  assign wb_dest = dest_q[(STAGES-1)*BR +: BR];
  assign wb_we   = valid_q[STAGES-1];

  // Youngest producer wins: scan oldest to youngest so the lowest index overwrites
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (valid_q[i] && (dest_q[i*BR +: BR] == rs) && (rs != '0)) fwd_rs = FW'(i + 1);
      if (valid_q[i] && (dest_q[i*BR +: BR] == rt) && (rt != '0)) fwd_rt = FW'(i + 1);
    end
  end

  // Conservative: rt compared even when it is the I-type destination
  always_comb begin
    load_use = valid_q[0] & load_q[0] &
               (((dest_q[BR-1:0] == rs) & (rs != '0)) |
                ((dest_q[BR-1:0] == rt) & (rt != '0)));
  end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed self-checking bench for dest_reg_pipe (BR=5, STAGES=3, LINK_REG=31).
module tb_dest_reg_pipe;

  logic        clk;
  logic        rst;
  logic [4:0]  rd, rt, rs;
  logic [1:0]  dst_sel;
  logic        reg_write, is_load, stall, flush;
  logic [14:0] dest_q;
  logic [2:0]  valid_q;
  logic [4:0]  wb_dest;
  logic        wb_we;
  logic [1:0]  fwd_rs, fwd_rt;
  logic        load_use;

  int n_cmp;
  int n_err;

  dest_reg_pipe #(.BR(5), .STAGES(3), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .rd(rd), .rt(rt), .rs(rs), .dst_sel(dst_sel),
    .reg_write(reg_write), .is_load(is_load), .stall(stall), .flush(flush),
    .dest_q(dest_q), .valid_q(valid_q), .wb_dest(wb_dest), .wb_we(wb_we),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .load_use(load_use)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dest_at(input int i);
    return int'(dest_q[i*5 +: 5]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] a_rd, input logic [4:0] a_rt, input logic [4:0] a_rs,
                        input logic [1:0] a_sel, input logic a_rw, input logic a_ld,
                        input logic a_stall, input logic a_flush);
    rd = a_rd; rt = a_rt; rs = a_rs; dst_sel = a_sel;
    reg_write = a_rw; is_load = a_ld; stall = a_stall; flush = a_flush;
    #1;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst_valid", int'(valid_q), 0);
    check("rst_dest", int'(dest_q), 0);
    check("rst_wb_we", int'(wb_we), 0);
    check("rst_load_use", int'(load_use), 0);
    @(negedge clk);
    rst = 1'b0;

    // R-type rd=5: stage 0 after one edge, WB after edge 3, one cycle only
    set_in(5'd5, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("rtype_dest0", dest_at(0), 5);
    check("rtype_valid0", int'(valid_q[0]), 1);
    check("rtype_we_e1", int'(wb_we), 0);
    idle();
    tick();
    check("rtype_dest1", dest_at(1), 5);
    check("rtype_we_e2", int'(wb_we), 0);
    tick();
    check("rtype_wb_dest", int'(wb_dest), 5);
    check("rtype_wb_we", int'(wb_we), 1);
    tick();
    check("rtype_we_after", int'(wb_we), 0);

    // JAL goes to r31
    set_in(5'd3, 5'd4, 5'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("jal_dest0", dest_at(0), 31);
    idle();
    tick();
    tick();
    check("jal_wb_dest", int'(wb_dest), 31);
    check("jal_wb_we", int'(wb_we), 1);

    // No-destination and write-to-$0 never become valid
    set_in(5'd6, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("nodst_valid0", int'(valid_q[0]), 0);
    set_in(5'd6, 5'd0, 5'd6, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nodst_fwd_rs", int'(fwd_rs), 0);
    tick();
    check("r0_valid0", int'(valid_q[0]), 0);
    idle();
    tick();
    check("nodst_wb_we", int'(wb_we), 0);
    tick();
    check("r0_wb_we", int'(wb_we), 0);

    // Back-to-back writes to r7: EX wins, then lone WB hit
    set_in(5'd7, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    set_in(5'd0, 5'd0, 5'd7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwd_rs_ex_wins", int'(fwd_rs), 1);
    check("fwd_rt_nohit", int'(fwd_rt), 0);
    check("rtype_no_load_use", int'(load_use), 0);
    idle();
    tick();
    tick();
    set_in(5'd0, 5'd7, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fwd_rt_wb", int'(fwd_rt), 3);
    check("fwd_rs_zero", int'(fwd_rs), 0);

    // lw r9 then dependent rs=9: load-use, stall, then forward from MEM
    set_in(5'd0, 5'd9, 5'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(5'd0, 5'd9, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use_rt", int'(load_use), 1);
    set_in(5'd0, 5'd0, 5'd9, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use_rs", int'(load_use), 1);
    check("lw_fwd_rs_ex", int'(fwd_rs), 1);
    set_in(5'd0, 5'd0, 5'd9, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("stall_bubble_valid0", int'(valid_q[0]), 0);
    check("stall_lw_mem_dest", dest_at(1), 9);
    check("stall_lw_mem_valid", int'(valid_q[1]), 1);
    set_in(5'd0, 5'd0, 5'd9, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_stall_load_use", int'(load_use), 0);
    check("after_stall_fwd_rs", int'(fwd_rs), 2);
    idle();
    tick();
    check("lw_retire_dest", int'(wb_dest), 9);
    check("lw_retire_we", int'(wb_we), 1);

    // Flush kills rd=4 and it never reaches WB
    set_in(5'd4, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("flush_valid0", int'(valid_q[0]), 0);
    check("flush_dest0", dest_at(0), 0);
    idle();
    tick();
    check("flush_we_e2", int'(wb_we), 0);
    tick();
    check("flush_we_e3", int'(wb_we), 0);

    // Stall+flush together gives exactly one bubble
    set_in(5'd4, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("sf_valid0", int'(valid_q[0]), 0);
    set_in(5'd8, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("sf_next_dest0", dest_at(0), 8);
    check("sf_next_valid", int'(valid_q), 1);

    // Reset mid-stream with three valid entries
    set_in(5'd1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(5'd2, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rst_valid", int'(valid_q), 7);
    set_in(5'd0, 5'd2, 5'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_fwd_rs", int'(fwd_rs), 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(valid_q), 0);
    check("mid_rst_wb_we", int'(wb_we), 0);
    check("mid_rst_fwd_rs", int'(fwd_rs), 0);
    check("mid_rst_fwd_rt", int'(fwd_rt), 0);
    tick();
    check("held_rst_fwd_rt", int'(fwd_rt), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
